// File: rtl/sd_word_bridge_if.sv
// Signal bundle around the SD byte / SPRAM word bridge.
// master = the bridge itself, slave = its surroundings (controller + SD channels).
interface sd_word_bridge_if #(
    parameter int SD_DATA_WIDTH       = 8,
    parameter int SD_ADDRESS_WIDTH    = 16,
    parameter int SPRAM_DATA_WIDTH    = 16,
    parameter int SPRAM_ADDRESS_WIDTH = 8
);
    logic [SD_ADDRESS_WIDTH-1:0]    sd_base_address;

    logic [SPRAM_ADDRESS_WIDTH-1:0] rd_req_address;
    logic                           rd_req_valid;
    logic                           rd_req_ready;
    logic [SPRAM_DATA_WIDTH-1:0]    rd_word_data;
    logic                           rd_word_valid;
    logic                           rd_word_ready;

    logic [SD_ADDRESS_WIDTH-1:0]    sd_read_axi_taddress;
    logic                           sd_read_axi_tvalid;
    logic                           sd_read_axi_tready;
    logic [SD_DATA_WIDTH-1:0]       sd_read_axi_tdata;

    logic [SPRAM_ADDRESS_WIDTH-1:0] wr_word_address;
    logic [SPRAM_DATA_WIDTH-1:0]    wr_word_data;
    logic                           wr_word_valid;
    logic                           wr_word_ready;

    logic [SD_ADDRESS_WIDTH-1:0]    sd_write_axi_taddress;
    logic [SD_DATA_WIDTH-1:0]       sd_write_axi_tdata;
    logic                           sd_write_axi_tvalid;
    logic                           sd_write_axi_tready;

    logic                           busy;

    modport master (
        input  sd_base_address,
        input  rd_req_address, rd_req_valid, rd_word_ready,
        output rd_req_ready, rd_word_data, rd_word_valid,
        output sd_read_axi_taddress, sd_read_axi_tvalid,
        input  sd_read_axi_tready, sd_read_axi_tdata,
        input  wr_word_address, wr_word_data, wr_word_valid,
        output wr_word_ready,
        output sd_write_axi_taddress, sd_write_axi_tdata, sd_write_axi_tvalid,
        input  sd_write_axi_tready,
        output busy
    );

    modport slave (
        output sd_base_address,
        output rd_req_address, rd_req_valid, rd_word_ready,
        input  rd_req_ready, rd_word_data, rd_word_valid,
        input  sd_read_axi_taddress, sd_read_axi_tvalid,
        output sd_read_axi_tready, sd_read_axi_tdata,
        output wr_word_address, wr_word_data, wr_word_valid,
        input  wr_word_ready,
        input  sd_write_axi_taddress, sd_write_axi_tdata, sd_write_axi_tvalid,
        output sd_write_axi_tready,
        input  busy
    );
endinterface

// File: rtl/sd_word_bridge.sv
// Word<->byte bridge: one word read = two SD byte reads, one word write = two SD byte writes; SD_WORD_BRIDGE_BYTE_SWAP_EN selects big-endian packing.
// Read word valid 3 cycles after accept (tready high); every valid holds until its handshake, tready low stalls indefinitely.
module sd_word_bridge #(
    parameter int SD_DATA_WIDTH       = 8,
    parameter int SD_ADDRESS_WIDTH    = 16,
    parameter int SPRAM_DATA_WIDTH    = 16,
    parameter int SPRAM_ADDRESS_WIDTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    sd_word_bridge_if.master bus
);
    localparam int DW = SD_DATA_WIDTH;
    localparam int AW = SD_ADDRESS_WIDTH;
    localparam int WW = SPRAM_DATA_WIDTH;

    // Bit position of the byte at the lo address (first) and hi address (second).
`ifdef SD_WORD_BRIDGE_BYTE_SWAP_EN
    localparam int FIRST_LSB  = DW;
    localparam int SECOND_LSB = 0;
`else
    localparam int FIRST_LSB  = 0;
    localparam int SECOND_LSB = DW;
`endif

    typedef enum logic [1:0] {R_IDLE, R_LO, R_HI, R_OUT} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_LO, W_HI}        wr_state_t;

    rd_state_t     rd_state_q, rd_state_d;
    logic [AW-1:0] rd_lo_q, rd_lo_d, rd_hi_q, rd_hi_d;
    logic [WW-1:0] rd_word_q, rd_word_d;

    wr_state_t     wr_state_q, wr_state_d;
    logic [AW-1:0] wr_lo_q, wr_lo_d, wr_hi_q, wr_hi_d;
    logic [WW-1:0] wr_word_q, wr_word_d;

    logic [AW-1:0] rd_req_lo, wr_req_lo;

    assign rd_req_lo = bus.sd_base_address + AW'({bus.rd_req_address, 1'b0});
    assign wr_req_lo = bus.sd_base_address + AW'({bus.wr_word_address, 1'b0});

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state_q <= R_IDLE;
            rd_lo_q    <= '0;
            rd_hi_q    <= '0;
            rd_word_q  <= '0;
            wr_state_q <= W_IDLE;
            wr_lo_q    <= '0;
            wr_hi_q    <= '0;
            wr_word_q  <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_lo_q    <= rd_lo_d;
            rd_hi_q    <= rd_hi_d;
            rd_word_q  <= rd_word_d;
            wr_state_q <= wr_state_d;
            wr_lo_q    <= wr_lo_d;
            wr_hi_q    <= wr_hi_d;
            wr_word_q  <= wr_word_d;
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_lo_d    = rd_lo_q;
        rd_hi_d    = rd_hi_q;
        rd_word_d  = rd_word_q;
        case (rd_state_q)
            R_IDLE: if (bus.rd_req_valid) begin
                rd_lo_d    = rd_req_lo;
                rd_hi_d    = rd_req_lo + AW'(1);
                rd_state_d = R_LO;
            end
            R_LO: if (bus.sd_read_axi_tready) begin
                rd_word_d[FIRST_LSB +: DW] = bus.sd_read_axi_tdata;
                rd_state_d                 = R_HI;
            end
            R_HI: if (bus.sd_read_axi_tready) begin
                rd_word_d[SECOND_LSB +: DW] = bus.sd_read_axi_tdata;
                rd_state_d                  = R_OUT;
            end
            R_OUT: if (bus.rd_word_ready) rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        wr_state_d = wr_state_q;
        wr_lo_d    = wr_lo_q;
        wr_hi_d    = wr_hi_q;
        wr_word_d  = wr_word_q;
        case (wr_state_q)
            W_IDLE: if (bus.wr_word_valid) begin
                wr_lo_d    = wr_req_lo;
                wr_hi_d    = wr_req_lo + AW'(1);
                wr_word_d  = bus.wr_word_data;
                wr_state_d = W_LO;
            end
            W_LO: if (bus.sd_write_axi_tready) wr_state_d = W_HI;
            W_HI: if (bus.sd_write_axi_tready) wr_state_d = W_IDLE;
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        bus.rd_req_ready         = 1'b0;
        bus.rd_word_valid        = 1'b0;
        bus.sd_read_axi_tvalid   = 1'b0;
        bus.sd_read_axi_taddress = '0;
        case (rd_state_q)
            R_IDLE: bus.rd_req_ready = 1'b1;
            R_LO: begin
                bus.sd_read_axi_tvalid   = 1'b1;
                bus.sd_read_axi_taddress = rd_lo_q;
            end
            R_HI: begin
                bus.sd_read_axi_tvalid   = 1'b1;
                bus.sd_read_axi_taddress = rd_hi_q;
            end
            R_OUT: bus.rd_word_valid = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        bus.wr_word_ready         = 1'b0;
        bus.sd_write_axi_tvalid   = 1'b0;
        bus.sd_write_axi_taddress = '0;
        bus.sd_write_axi_tdata    = '0;
        case (wr_state_q)
            W_IDLE: bus.wr_word_ready = 1'b1;
            W_LO: begin
                bus.sd_write_axi_tvalid   = 1'b1;
                bus.sd_write_axi_taddress = wr_lo_q;
                bus.sd_write_axi_tdata    = wr_word_q[FIRST_LSB +: DW];
            end
            W_HI: begin
                bus.sd_write_axi_tvalid   = 1'b1;
                bus.sd_write_axi_taddress = wr_hi_q;
                bus.sd_write_axi_tdata    = wr_word_q[SECOND_LSB +: DW];
            end
            default: ;
        endcase
    end

    assign bus.rd_word_data = rd_word_q;
    assign bus.busy         = (rd_state_q != R_IDLE) || (wr_state_q != W_IDLE);

endmodule

// File: tb/tb_sd_word_bridge.sv
// Bench for sd_word_bridge: directed scenarios plus random traffic, scored against a transaction-level model.
// Build with SD_WORD_BRIDGE_BYTE_SWAP_EN defined to exercise big-endian packing.
module tb_sd_word_bridge;
`ifdef SD_WORD_BRIDGE_BYTE_SWAP_EN
    localparam bit SWAP = 1'b1;
`else
    localparam bit SWAP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sd_word_bridge_if bif ();
    sd_word_bridge dut (.clk(clk), .reset(reset), .bus(bif));

    logic [7:0] sd_mem [0:65535];
    assign bif.sd_read_axi_tdata = sd_mem[bif.sd_read_axi_taddress];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: addresses and byte lanes straight from the word/byte mapping rules.
    function automatic logic [15:0] lo_of(input logic [15:0] base, input logic [7:0] a);
        return 16'((int'(base) + 2 * int'(a)) % 65536);
    endfunction
    function automatic logic [15:0] hi_of(input logic [15:0] lo);
        return 16'((int'(lo) + 1) % 65536);
    endfunction
    function automatic logic [7:0] byte_of(input logic [15:0] w, input int k);
        logic [7:0] first, second;
        first  = SWAP ? w[15:8] : w[7:0];
        second = SWAP ? w[7:0]  : w[15:8];
        return (k == 0) ? first : second;
    endfunction
    function automatic logic [15:0] exp_word(input logic [15:0] lo);
        logic [7:0] b0, b1;
        b0 = sd_mem[lo];
        b1 = sd_mem[hi_of(lo)];
        return SWAP ? {b0, b1} : {b1, b0};
    endfunction

    bit          rd_busy_m = 0, wr_busy_m = 0;
    int          rd_nb = 0, wr_nb = 0;
    logic [15:0] rd_lo_m, rd_word_m, wr_lo_m, wr_word_m;
    int          rd_acc_cnt = 0, wr_acc_cnt = 0;
    logic [15:0] rd_log [$];
    logic [23:0] wr_log [$];

    // Monitor at the falling edge: check outputs against the model, then apply this cycle's handshakes.
    always @(negedge clk) begin
        bit rd_acc, rd_xfer, word_xfer, wr_acc, wr_xfer;
        chk("busy", bif.busy, rd_busy_m || wr_busy_m);
        chk("rd_req_ready", bif.rd_req_ready, !rd_busy_m);
        chk("sd_rd_vld", bif.sd_read_axi_tvalid, rd_busy_m && rd_nb < 2);
        chk("rd_word_vld", bif.rd_word_valid, rd_busy_m && rd_nb == 2);
        chk("wr_word_ready", bif.wr_word_ready, !wr_busy_m);
        chk("sd_wr_vld", bif.sd_write_axi_tvalid, wr_busy_m);
        if (rd_busy_m && rd_nb < 2)
            chk("sd_rd_addr", bif.sd_read_axi_taddress, (rd_nb == 0) ? rd_lo_m : hi_of(rd_lo_m));
        if (rd_busy_m && rd_nb == 2)
            chk("rd_word_data", bif.rd_word_data, rd_word_m);
        if (wr_busy_m) begin
            chk("sd_wr_addr", bif.sd_write_axi_taddress, (wr_nb == 0) ? wr_lo_m : hi_of(wr_lo_m));
            chk("sd_wr_data", bif.sd_write_axi_tdata, byte_of(wr_word_m, wr_nb));
        end
        if (reset) begin
            rd_busy_m = 0; rd_nb = 0;
            wr_busy_m = 0; wr_nb = 0;
        end else begin
            rd_acc    = bif.rd_req_valid && !rd_busy_m;
            rd_xfer   = rd_busy_m && rd_nb < 2 && bif.sd_read_axi_tready;
            word_xfer = rd_busy_m && rd_nb == 2 && bif.rd_word_ready;
            wr_acc    = bif.wr_word_valid && !wr_busy_m;
            wr_xfer   = wr_busy_m && bif.sd_write_axi_tready;
            if (rd_xfer) begin
                rd_log.push_back(bif.sd_read_axi_taddress);
                rd_nb++;
            end
            if (word_xfer) rd_busy_m = 0;
            if (rd_acc) begin
                rd_busy_m = 1;
                rd_nb     = 0;
                rd_lo_m   = lo_of(bif.sd_base_address, bif.rd_req_address);
                rd_word_m = exp_word(rd_lo_m);
                rd_acc_cnt++;
            end
            if (wr_xfer) begin
                wr_log.push_back({bif.sd_write_axi_taddress, bif.sd_write_axi_tdata});
                wr_nb++;
                if (wr_nb == 2) wr_busy_m = 0;
            end
            if (wr_acc) begin
                wr_busy_m = 1;
                wr_nb     = 0;
                wr_lo_m   = lo_of(bif.sd_base_address, bif.wr_word_address);
                wr_word_m = bif.wr_word_data;
                wr_acc_cnt++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_acc(input bit need_r, input bit need_w, input int r0, input int w0, input string tag);
        int k = 0;
        while (((need_r && rd_acc_cnt == r0) || (need_w && wr_acc_cnt == w0)) && k < 50) begin
            step(1);
            k++;
        end
        chk(tag, k < 50, 1);
        if (need_r) bif.rd_req_valid = 1'b0;
        if (need_w) bif.wr_word_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while ((rd_busy_m || wr_busy_m) && k < 50) begin
            step(1);
            k++;
        end
        chk(tag, bif.busy, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, w0, k, rd_seen, wr_seen, rs0;
        for (int i = 0; i < 65536; i++) sd_mem[i] = 8'($urandom);
        sd_mem[16'h100A] = 8'hAB;
        sd_mem[16'h100B] = 8'hCD;

        bif.sd_base_address     = '0;
        bif.rd_req_address      = '0;
        bif.rd_req_valid        = 1'b0;
        bif.rd_word_ready       = 1'b0;
        bif.sd_read_axi_tready  = 1'b0;
        bif.wr_word_address     = '0;
        bif.wr_word_data        = '0;
        bif.wr_word_valid       = 1'b0;
        bif.sd_write_axi_tready = 1'b0;

        step(2);
        chk("rst_rd_req_ready", bif.rd_req_ready, 1);
        chk("rst_wr_word_ready", bif.wr_word_ready, 1);
        chk("rst_rd_word_valid", bif.rd_word_valid, 0);
        chk("rst_sd_rd_vld", bif.sd_read_axi_tvalid, 0);
        chk("rst_sd_wr_vld", bif.sd_write_axi_tvalid, 0);
        chk("rst_busy", bif.busy, 0);
        chk("rst_sd_rd_addr", bif.sd_read_axi_taddress, 0);
        chk("rst_sd_wr_addr", bif.sd_write_axi_taddress, 0);
        chk("rst_sd_wr_data", bif.sd_write_axi_tdata, 0);
        chk("rst_rd_word_data", bif.rd_word_data, 0);
        reset = 1'b0;
        step(1);

        // Directed read: latency and packing.
        bif.sd_base_address    = 16'h1000;
        bif.rd_req_address     = 8'h05;
        bif.sd_read_axi_tready = 1'b1;
        bif.rd_word_ready      = 1'b1;
        bif.rd_req_valid       = 1'b1;
        r0 = rd_acc_cnt;
        wait_acc(1, 0, r0, 0, "t1_accept");
        k = 1;
        while (!bif.rd_word_valid && k < 20) begin
            step(1);
            k++;
        end
        chk("t1_latency", k, 3);
        chk("t1_word", bif.rd_word_data, SWAP ? 16'hABCD : 16'hCDAB);
        step(1);

        // Directed write: byte order and ready-low window.
        bif.sd_base_address     = 16'h0200;
        bif.wr_word_address     = 8'h10;
        bif.wr_word_data        = 16'h1234;
        bif.sd_write_axi_tready = 1'b1;
        bif.wr_word_valid       = 1'b1;
        w0 = wr_log.size();
        wait_acc(0, 1, 0, wr_acc_cnt, "t2_accept");
        k = 0;
        while (!bif.wr_word_ready && k < 20) begin
            k++;
            step(1);
        end
        chk("t2_ready_low", k, 2);
        chk("t2_nwrites", wr_log.size() - w0, 2);
        chk("t2_write0", wr_log[w0],     {16'h0220, SWAP ? 8'h12 : 8'h34});
        chk("t2_write1", wr_log[w0 + 1], {16'h0221, SWAP ? 8'h34 : 8'h12});

        // Backpressure on the SD read and on the word consumer.
        bif.sd_read_axi_tready = 1'b0;
        bif.rd_word_ready      = 1'b0;
        bif.sd_base_address    = 16'h3000;
        bif.rd_req_address     = 8'h21;
        bif.rd_req_valid       = 1'b1;
        wait_acc(1, 0, rd_acc_cnt, 0, "t3_accept");
        step(5);
        chk("t3_sd_vld_held", bif.sd_read_axi_tvalid, 1);
        chk("t3_sd_addr", bif.sd_read_axi_taddress, 16'h3042);
        chk("t3_req_ready", bif.rd_req_ready, 0);
        bif.sd_read_axi_tready = 1'b1;
        k = 0;
        while (!bif.rd_word_valid && k < 20) begin
            step(1);
            k++;
        end
        chk("t3_word_seen", bif.rd_word_valid, 1);
        bif.sd_read_axi_tready = 1'b0;
        step(4);
        chk("t3_word_vld_held", bif.rd_word_valid, 1);
        chk("t3_req_ready2", bif.rd_req_ready, 0);
        chk("t3_word", bif.rd_word_data, exp_word(16'h3042));
        bif.rd_word_ready = 1'b1;
        step(1);
        chk("t3_back_idle", bif.rd_req_ready, 1);

        // Address wrap with both paths started in the same cycle.
        r0 = rd_log.size();
        w0 = wr_log.size();
        bif.sd_base_address     = 16'hFFFF;
        bif.rd_req_address      = 8'h00;
        bif.wr_word_address     = 8'h00;
        bif.wr_word_data        = 16'hC35A;
        bif.sd_read_axi_tready  = 1'b1;
        bif.sd_write_axi_tready = 1'b1;
        bif.rd_req_valid        = 1'b1;
        bif.wr_word_valid       = 1'b1;
        wait_acc(1, 1, rd_acc_cnt, wr_acc_cnt, "t4_accept");
        wait_idle("t4_idle");
        chk("t4_rd_n", rd_log.size() - r0, 2);
        chk("t4_rd_lo", rd_log[r0], 16'hFFFF);
        chk("t4_rd_hi", rd_log[r0 + 1], 16'h0000);
        chk("t4_wr_n", wr_log.size() - w0, 2);
        chk("t4_wr_lo", wr_log[w0],     {16'hFFFF, SWAP ? 8'hC3 : 8'h5A});
        chk("t4_wr_hi", wr_log[w0 + 1], {16'h0000, SWAP ? 8'h5A : 8'hC3});

        // Reset while the read is in R_HI and the write is stalled in W_LO.
        r0 = rd_log.size();
        w0 = wr_log.size();
        bif.sd_base_address     = 16'h4400;
        bif.rd_req_address      = 8'h07;
        bif.wr_word_address     = 8'h09;
        bif.wr_word_data        = 16'h9999;
        bif.sd_write_axi_tready = 1'b0;
        bif.rd_req_valid        = 1'b1;
        bif.wr_word_valid       = 1'b1;
        wait_acc(1, 1, rd_acc_cnt, wr_acc_cnt, "t5_accept");
        step(1);
        chk("t5_busy_before", bif.busy, 1);
        reset                   = 1'b1;
        bif.sd_read_axi_tready  = 1'b0;
        bif.sd_write_axi_tready = 1'b0;
        step(1);
        reset = 1'b0;
        chk("t5_busy", bif.busy, 0);
        chk("t5_rd_req_ready", bif.rd_req_ready, 1);
        chk("t5_wr_word_ready", bif.wr_word_ready, 1);
        chk("t5_rd_word_vld", bif.rd_word_valid, 0);
        chk("t5_sd_rd_vld", bif.sd_read_axi_tvalid, 0);
        chk("t5_sd_wr_vld", bif.sd_write_axi_tvalid, 0);
        bif.sd_read_axi_tready  = 1'b1;
        bif.sd_write_axi_tready = 1'b1;
        step(3);
        chk("t5_rd_xfers", rd_log.size() - r0, 1);
        chk("t5_wr_xfers", wr_log.size() - w0, 0);

        // Random traffic on both paths.
        rd_seen = rd_acc_cnt;
        wr_seen = wr_acc_cnt;
        rs0     = rd_acc_cnt;
        for (int c = 0; c < 3000; c++) begin
            bif.sd_read_axi_tready  = ($urandom_range(0, 3) != 0);
            bif.sd_write_axi_tready = ($urandom_range(0, 3) != 0);
            bif.rd_word_ready       = ($urandom_range(0, 2) != 0);
            bif.sd_base_address     = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom);
            if (bif.rd_req_valid && rd_acc_cnt != rd_seen) bif.rd_req_valid = 1'b0;
            if (bif.wr_word_valid && wr_acc_cnt != wr_seen) bif.wr_word_valid = 1'b0;
            rd_seen = rd_acc_cnt;
            wr_seen = wr_acc_cnt;
            if (!bif.rd_req_valid && $urandom_range(0, 1) == 1) begin
                bif.rd_req_address = 8'($urandom);
                bif.rd_req_valid   = 1'b1;
            end
            if (!bif.wr_word_valid && $urandom_range(0, 1) == 1) begin
                bif.wr_word_address = 8'($urandom);
                bif.wr_word_data    = 16'($urandom);
                bif.wr_word_valid   = 1'b1;
            end
            step(1);
        end
        bif.rd_req_valid        = 1'b0;
        bif.wr_word_valid       = 1'b0;
        bif.sd_read_axi_tready  = 1'b1;
        bif.sd_write_axi_tready = 1'b1;
        bif.rd_word_ready       = 1'b1;
        step(1);
        wait_idle("rand_drain");
        chk("rand_progress", (rd_acc_cnt - rs0) > 200, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
